// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge front end: transfer types,
// arbiter state encoding and a constant-evaluable clog2.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester strictly after
// pointer, wrapping; returns both one-hot grant and its index.
module rr_arbiter
  import ahb_apb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [IDX_W-1:0]       pointer,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = IDX_W'((int'(pointer) + off) % NUM_MASTERS);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/ahb2apb_master_arbiter.sv
// Round-robin front end that lets several one-shot requesters share the
// AHB side of the AHB-to-APB bridge, one NONSEQ single transfer at a time.
module ahb2apb_master_arbiter
  import ahb_apb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        req_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] req_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] req_wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        done,
  output logic                          err,
  output logic [DATA_W-1:0]             rdata,
  output logic                          hselapb,
  output logic [1:0]                    htrans,
  output logic [ADDR_W-1:0]             haddr,
  output logic                          hwrite,
  output logic [DATA_W-1:0]             hwdata,
  input  logic                          hready,
  input  logic                          hresp,
  input  logic [DATA_W-1:0]             hrdata
);

  localparam int IDX_W = clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

  arb_state_e             state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [NUM_MASTERS-1:0] mask_q;
  logic                   write_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] sel_gnt;
  logic [IDX_W-1:0]       sel_idx;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   stall_expired;

  // The previous winner is excluded for exactly one IDLE cycle after RESP.
  assign eligible = req & ~mask_q;

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_rr (
    .eligible(eligible),
    .pointer (ptr_q),
    .grant   (sel_gnt),
    .idx     (sel_idx)
  );

  assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign stall_expired = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      gidx_q  <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          mask_q <= '0;
          if (|eligible) begin
            gidx_q  <= sel_idx;
            gnt     <= sel_gnt;
            write_q <= req_write[sel_idx];
            addr_q  <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
            cnt_q   <= '0;
            state_q <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (hready) begin
            cnt_q   <= '0;
            state_q <= ARB_DATA;
          end else if (stall_expired) begin
            done    <= gnt;
            err     <= 1'b1;
            rdata   <= '0;
            state_q <= ARB_RESP;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ARB_DATA: begin
          if (hready) begin
            done    <= gnt;
            err     <= hresp;
            rdata   <= write_q ? '0 : hrdata;
            state_q <= ARB_RESP;
          end else if (stall_expired) begin
            done    <= gnt;
            err     <= 1'b1;
            rdata   <= '0;
            state_q <= ARB_RESP;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ARB_RESP: begin
          done    <= '0;
          err     <= 1'b0;
          rdata   <= '0;
          gnt     <= '0;
          ptr_q   <= gidx_q;
          mask_q  <= gnt;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Bus side is a pure decode of state and latched payload; req never reaches it.
  assign hselapb = (state_q == ARB_ADDR);
  assign htrans  = (state_q == ARB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr   = (state_q == ARB_ADDR) ? addr_q : '0;
  assign hwrite  = (state_q == ARB_ADDR) ? write_q : 1'b0;
  assign hwdata  = (state_q == ARB_DATA) ? wdata_q : '0;

endmodule

// File: doc/ahb2apb_master_arbiter.md
Name: ahb2apb_master_arbiter

Overview:
- Shares the single AHB-to-APB bridge slave port between NUM_MASTERS simple requesters using round-robin arbitration.
- Each requester presents a one-shot read/write request. The arbiter latches the request and sequences one AHB-Lite NONSEQ single transfer through the bridge (address phase, then data phase, honouring hready/hresp). It then returns read data and completion status to the winning requester.
- Sits between on-chip requesters and the bridge's AHB-side inputs. It is the only driver of those inputs.

Parameters:
- NUM_MASTERS, 2, number of requesters (legal values 2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum consecutive hready-low cycles per phase before abort; 0 disables the timeout.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  reset, asynchronous, active-low.
- req  in  NUM_MASTERS  per-requester request level, held until that requester's done.
- req_write  in  NUM_MASTERS  1=write, 0=read; stable while req is high.
- req_addr  in  NUM_MASTERS*ADDR_W  packed per-requester address; slice i = [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_MASTERS*DATA_W  packed per-requester write data.
- gnt  out  NUM_MASTERS  one-hot; high from acceptance through the RESP cycle.
- done  out  NUM_MASTERS  one-cycle completion pulse to the granted requester.
- err  out  1  qualifies done: 1 = hresp error or timeout.
- rdata  out  DATA_W  read data; valid only while done is high.
- hselapb  out  1  bridge select.
- htrans  out  2  AHB transfer type.
- haddr  out  ADDR_W  AHB address.
- hwrite  out  1  AHB write.
- hwdata  out  DATA_W  AHB write data.
- hready  in  1  bridge ready.
- hresp  in  1  bridge response (1 = error).
- hrdata  in  DATA_W  bridge read data.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, rr pointer=NUM_MASTERS-1, mask=0. All outputs are 0: gnt, done, err, rdata, hselapb, htrans=2'b00, haddr, hwrite, hwdata.
- Reset asserted mid-transfer aborts the transfer immediately. No done pulse is produced. The bridge shares hresetn.
- State machine, 4 states:
  - IDLE: eligible = req & ~mask. If eligible is nonzero, pick the first set bit searching from pointer+1 upward with wrap. Latch that requester's write/addr/wdata into internal registers, set gnt one-hot, clear the timeout counter, go to ADDR. Otherwise stay in IDLE.
  - ADDR: hselapb=1, htrans=2'b10 (NONSEQ), haddr/hwrite from the latched registers. If hready=1, go to DATA and clear the counter. Otherwise hold all address-phase outputs stable and increment the counter.
  - DATA: hselapb=0, htrans=2'b00, hwdata=latched wdata (driven for reads too). If hready=1, capture hrdata into rdata (reads only; rdata is 0 for writes), set err=hresp, go to RESP. Otherwise increment the counter.
  - RESP: done[g]=1 for one cycle, err valid, gnt held. Set pointer=g, mask=one-hot(g), go to IDLE.
- Timeout: if TIMEOUT≠0 and the counter reaches TIMEOUT in ADDR or DATA, go to RESP with err=1 and rdata=0. On the next cycle the bus outputs return to idle values (hselapb=0, htrans=2'b00).
- Mask: cleared in the cycle after the IDLE cycle that follows RESP, giving exactly one masked IDLE cycle. Requesters drop req in the cycle after done. Another requester may be granted in that masked cycle.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- gnt, done, err and rdata are registered. haddr/htrans/hselapb/hwrite/hwdata are decoded from state plus registered payload, with no combinational path from req.
- Minimum occupancy is 4 cycles per transfer (IDLE, ADDR, DATA, RESP), plus bridge wait states.
- Requester changes to req_addr/req_write/req_wdata after acceptance have no effect.
- req dropped before done is ignored once accepted: the transfer still completes and done still pulses.
- Single-requester back-to-back: the mask enforces one idle cycle between transfers.
- htrans is only ever 2'b00 or 2'b10. There are no bursts and no pipelined address overlap.

Decomposition:
- Shared package ahb_apb_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10;
  - arbiter state encoding (ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_RESP);
  - a clog2 function.
- One sub-module, rr_arbiter: combinational round-robin pick (inputs eligible and pointer; outputs one-hot grant and index). It is reused by later multi-slave bridges.

Test Plan:
- Single write: req[0]=1, write, addr=32'h10, wdata=32'hA5A5_0001, behind the bridge → one NONSEQ cycle with haddr=32'h10; bridge drives paddr=32'h10, pwdata=32'hA5A5_0001, pwrite=1; done[0] pulses once with err=0.
- Single read: req[1]=1, addr=32'h20, APB model prdata=32'hDEAD_BEEF → done[1] with rdata=32'hDEAD_BEEF, err=0; gnt[1] high from the ADDR cycle through RESP.
- Contention: req=2'b11 asserted together and re-asserted after each done, for 6 transfers → grant order 0,1,0,1,0,1; no requester starves.
- Stall and timeout: TIMEOUT=4, bridge model holds hready=0 in the data phase → done plus err=1 exactly 4 stalled cycles later, rdata=0, htrans=2'b00 afterwards. With hready=0 for 3 cycles → normal completion.
- Error response: model asserts hresp=1 with hready=1 in the data phase → done with err=1; the next request proceeds normally.
- Reset mid-transfer: hresetn low during DATA → all outputs 0 asynchronously, no done pulse; after release, a pending req[0] is granted first (pointer at reset value).
